// File: rtl/memory_arbiter.sv
// Four-requester round-robin arbiter in front of a single-port synchronous memory.
// Each granted access runs IDLE -> ACCESS -> WAIT -> DONE with all outputs registered.
module memory_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [3:0]            gnt,
  output logic [3:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  mem_write_readBar,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]          win_idx;
  logic [1:0]          cand;
  logic                win_found;

  // Round-robin search: first requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    ack_d    = 4'b0000;
    mem_wr_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d  = StAccess;
          sel_d    = win_idx;
          gnt_d    = 4'b0001 << win_idx;
          mem_wr_d = we[win_idx];
          addr_d   = addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d  = wdata[int'(win_idx)*DATA_W +: DATA_W];
        end
      end
      StAccess: begin
        state_d = StWait;
      end
      StWait: begin
        // Memory returns data one cycle after the address; capture it for reads and writes alike.
        state_d = StDone;
        rdata_d = mem_data_out;
        ack_d   = gnt_q;
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = sel_q + 2'd1;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= 2'd0;
      sel_q    <= 2'd0;
      gnt_q    <= 4'b0000;
      ack_q    <= 4'b0000;
      busy_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      mem_wr_q <= mem_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt               = gnt_q;
  assign ack               = ack_q;
  assign busy              = busy_q;
  assign rdata             = rdata_q;
  assign mem_write_readBar = mem_wr_q;
  assign mem_address       = addr_q;
  assign mem_data_in       = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a synchronous memory model and a backdoor preload port.
module tb_memory_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        req, we;
  logic [4*AW-1:0]   addr;
  logic [4*DW-1:0]   wdata;
  logic [3:0]        gnt, ack;
  logic [DW-1:0]     rdata;
  logic              busy, mem_write_readBar;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data_in, mem_data_out;

  logic [DW-1:0]     mem [0:(1<<AW)-1];
  logic              bd_we;
  logic [AW-1:0]     bd_addr;
  logic [DW-1:0]     bd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .we                (we),
    .addr              (addr),
    .wdata             (wdata),
    .gnt               (gnt),
    .ack               (ack),
    .rdata             (rdata),
    .busy              (busy),
    .mem_write_readBar (mem_write_readBar),
    .mem_address       (mem_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write_readBar) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    we[i]            = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  // One full read transaction from IDLE with req already driven; returns in IDLE.
  task automatic run_read(input int idx, input logic [DW-1:0] exp_rd);
    tick();
    check($sformatf("gnt_r%0d", idx), 64'(gnt), 64'(4'b0001 << idx));
    tick();
    tick();
    check($sformatf("ack_r%0d", idx), 64'(ack), 64'(4'b0001 << idx));
    check($sformatf("rdata_r%0d", idx), 64'(rdata), 64'(exp_rd));
    tick();
    check($sformatf("ack_clr_r%0d", idx), 64'(ack), 64'(4'b0000));
  endtask

  initial begin
    reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    #3;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mwr", 64'(mem_write_readBar), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    poke(10'd1, 32'd11);
    poke(10'd2, 32'd22);
    poke(10'd3, 32'd33);
    poke(10'd4, 32'd44);
    poke(10'd32, 32'd555);
    reset = 1'b1;
    tick();

    // Single write then read at address 16 by requester 0.
    set_req(0, 1'b1, 10'd16, 32'd10);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    check("wr_gnt", 64'(gnt), 64'(4'b0001));
    check("wr_busy", 64'(busy), 64'(1));
    check("wr_mwr_access", 64'(mem_write_readBar), 64'(1));
    check("wr_maddr", 64'(mem_address), 64'(16));
    check("wr_mdin", 64'(mem_data_in), 64'(10));
    tick();
    check("wr_mwr_wait", 64'(mem_write_readBar), 64'(0));
    check("wr_ack_wait", 64'(ack), 64'(0));
    tick();
    check("wr_mwr_done", 64'(mem_write_readBar), 64'(0));
    check("wr_ack", 64'(ack), 64'(4'b0001));
    tick();
    check("wr_idle_ack", 64'(ack), 64'(0));
    check("wr_idle_gnt", 64'(gnt), 64'(0));
    check("wr_idle_busy", 64'(busy), 64'(0));
    check("wr_idle_maddr_hold", 64'(mem_address), 64'(16));
    set_req(0, 1'b0, 10'd16, 32'd0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    check("rd_mwr", 64'(mem_write_readBar), 64'(0));
    tick();
    check("rd_ack_early", 64'(ack), 64'(0));
    tick();
    check("rd_ack", 64'(ack), 64'(4'b0001));
    check("rd_rdata", 64'(rdata), 64'(10));
    tick();
    check("rd_rdata_hold", 64'(rdata), 64'(10));

    // Contention from a fresh pointer: order 0,1,2,3,0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 10'(i + 1), 32'd0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) run_read(k % 4, 32'(((k % 4) + 1) * 11));
    req = 4'b0000;

    // Pointer is now 1: serve 3 (wraps pointer to 0), then 1001 gives 0 then 3.
    req = 4'b1000;
    run_read(3, 32'd44);
    req = 4'b1001;
    run_read(0, 32'd11);
    run_read(3, 32'd44);
    req = 4'b0000;

    // Reset during ACCESS of a write by requester 2.
    set_req(2, 1'b1, 10'd32, 32'd100);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("rw_gnt", 64'(gnt), 64'(4'b0100));
    check("rw_mwr", 64'(mem_write_readBar), 64'(1));
    reset = 1'b0;
    #1;
    check("rw_async_mwr", 64'(mem_write_readBar), 64'(0));
    check("rw_async_gnt", 64'(gnt), 64'(0));
    check("rw_async_busy", 64'(busy), 64'(0));
    check("rw_async_maddr", 64'(mem_address), 64'(0));
    check("rw_async_mdin", 64'(mem_data_in), 64'(0));
    check("rw_async_rdata", 64'(rdata), 64'(0));
    tick();
    tick();
    check("rw_no_ack", 64'(ack), 64'(0));
    reset = 1'b1;
    tick();
    check("rw_post_busy", 64'(busy), 64'(0));
    set_req(2, 1'b0, 10'd32, 32'd0);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("rw_rd_gnt", 64'(gnt), 64'(4'b0100));
    tick();
    tick();
    check("rw_rd_ack", 64'(ack), 64'(4'b0100));
    check("rw_rd_rdata", 64'(rdata), 64'(555));
    tick();

    // Requester 1 drops req during WAIT.
    set_req(1, 1'b0, 10'd16, 32'd0);
    req = 4'b0010;
    tick();
    check("drop_gnt", 64'(gnt), 64'(4'b0010));
    tick();
    req = 4'b0000;
    tick();
    check("drop_ack", 64'(ack), 64'(4'b0010));
    check("drop_rdata", 64'(rdata), 64'(10));
    tick();
    check("drop_ack_clr", 64'(ack), 64'(0));
    tick();
    tick();
    check("drop_no_busy", 64'(busy), 64'(0));
    check("drop_no_gnt", 64'(gnt), 64'(0));

    // Idle for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_gnt", 64'(gnt), 64'(0));
      check("idle_mwr", 64'(mem_write_readBar), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 10, memory word-address width; DATA_W, 32, memory data width; the requester count is fixed at 4.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester access request; bit i is requester i.
REQ-005 we  input  4  per-requester write enable: 1 = write, 0 = read.
REQ-006 addr  input  4*ADDR_W  per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-007 wdata  input  4*DATA_W  per-requester write data; requester i uses slice [i*DATA_W +: DATA_W].
REQ-008 gnt  output  4  one-hot grant; high from ACCESS through DONE of the granted transaction.
REQ-009 ack  output  4  one-hot, one-cycle completion pulse.
REQ-010 rdata  output  DATA_W  read data, valid while ack is high.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 mem_write_readBar  output  1  memory write strobe (1 = write, 0 = read).
REQ-013 mem_address  output  ADDR_W  memory address.
REQ-014 mem_data_in  output  DATA_W  memory write data.
REQ-015 mem_data_out  input  DATA_W  memory read data; valid one cycle after the address is presented.

Function
REQ-016 The FSM SHALL have exactly four states, each lasting one cycle except IDLE: IDLE, ACCESS, WAIT, DONE.
REQ-017 Transitions SHALL be:
  - IDLE -> ACCESS when any req bit is high at the edge.
  - ACCESS -> WAIT, unconditionally.
  - WAIT -> DONE, unconditionally.
  - DONE -> IDLE, unconditionally.
REQ-018 On the IDLE->ACCESS edge the block SHALL select the winner i by round-robin, searching from priority pointer ptr upward with modulo-4 wrap.
REQ-019 On the same edge the block SHALL latch we[i], addr slice i and wdata slice i into internal registers, and gnt SHALL become one-hot i.
REQ-020 mem_address and mem_data_in SHALL drive the latched values in ACCESS, WAIT and DONE, and hold their last value in IDLE.
REQ-021 mem_write_readBar SHALL be 1 only in ACCESS with latched we=1, and 0 in every other state and cycle.
REQ-022 On the WAIT->DONE edge rdata SHALL load mem_data_out; on writes rdata SHALL still load, and the value is don't-care.
REQ-023 In DONE ack[i] SHALL be 1 for exactly one cycle; on the DONE->IDLE edge ptr SHALL become (i+1) mod 4 and gnt SHALL clear.
REQ-024 Latency SHALL be: req sampled at edge t0 -> ack high between edges t2 and t3; minimum request-to-request period is 4 cycles.
REQ-025 Requester inputs SHALL be ignored outside IDLE; a req dropped mid-transaction SHALL NOT abort it, and the transaction completes with ack.
REQ-026 A req still high in the IDLE cycle after its ack SHALL be treated as a new request; requesters deassert req in the cycle after ack.
REQ-027 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than 3 other transactions.
REQ-028 ptr=3 with the winner at index 3 SHALL wrap ptr to 0.
REQ-029 rdata SHALL hold its value until the next WAIT->DONE edge.

Reset
REQ-030 While reset=0 the block SHALL immediately (asynchronously) force:
  - state IDLE and ptr=0;
  - gnt, ack and busy = 0;
  - mem_write_readBar, mem_address, mem_data_in and rdata = 0.
REQ-031 Reset asserted during ACCESS of a write SHALL drop mem_write_readBar without waiting for a clock edge.
REQ-032 The aborted transaction SHALL NOT complete and SHALL produce no ack; the first request after reset release follows REQ-017.

Verification
REQ-033 Single write/read: req[0]=1, we[0]=1, addr=16, wdata=10; after ack, read addr 16 -> ack[0] 3 cycles after sampling, rdata=10, mem_write_readBar high exactly 1 cycle.
REQ-034 Contention: req=4'b1111 held, each we=0, addresses 1..4 preloaded with 11..44 -> acks in order 0,1,2,3, then 0 again, every 4 cycles, with the matching rdata.
REQ-035 Round-robin wrap: serve requester 3, then raise req=4'b1001 -> requester 0 wins, then 3.
REQ-036 Reset mid-write: write addr 32, data 100 by requester 2, pull reset low during ACCESS -> all outputs 0 immediately, no ack, and a later read of addr 32 returns the pre-reset memory value.
REQ-037 Req drop: requester 1 drops req in WAIT -> ack[1] still pulses in DONE, and no second transaction starts.
REQ-038 Idle check: req=0 for 20 cycles -> busy=0, gnt=0, mem_write_readBar=0 throughout.
